// File: rtl/l2_arbiter.sv
// l2_arbiter: shares the single CPU-side L2 port between the L1 I-cache
// (read-only) and the L1 D-cache (read/write). It owns one transaction at a
// time, from grant to l2_mem_resp. On contention it grants round-robin. It
// latches the winner's address, data and opcode so the L2 sees stable
// values for the whole miss.
module l2_arbiter #(
  parameter int ADDR_W = 16,
  parameter int LINE_W = 128
) (
  input  logic              clk,
  input  logic              reset,
  // I-cache side
  input  logic              i_pmem_read,
  input  logic [ADDR_W-1:0] i_pmem_address,
  output logic [LINE_W-1:0] i_pmem_rdata,
  output logic              i_pmem_resp,
  // D-cache side
  input  logic              d_pmem_read,
  input  logic              d_pmem_write,
  input  logic [ADDR_W-1:0] d_pmem_address,
  input  logic [LINE_W-1:0] d_pmem_wdata,
  output logic [LINE_W-1:0] d_pmem_rdata,
  output logic              d_pmem_resp,
  // L2 side
  output logic              l2_mem_read,
  output logic              l2_mem_write,
  output logic [ADDR_W-1:0] l2_mem_address,
  output logic [LINE_W-1:0] l2_mem_wdata,
  input  logic [LINE_W-1:0] l2_mem_rdata,
  input  logic              l2_mem_resp
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } state_t;

  // last_grant: 0 = I-cache was served last, 1 = D-cache was served last
  state_t            state_reg, state_next;
  logic              last_grant_reg, last_grant_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic [LINE_W-1:0] wdata_reg, wdata_next;
  logic              op_write_reg, op_write_next;

  logic i_req;
  logic d_req;
  logic grant_i;
  logic grant_d;

  // A requester wins if it is alone, or if both ask and it was not served last.
  assign i_req   = i_pmem_read;
  assign d_req   = d_pmem_read | d_pmem_write;
  assign grant_i = i_req & (~d_req | last_grant_reg);
  assign grant_d = d_req & (~i_req | ~last_grant_reg);

  // State, fairness flag and latched request registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= IDLE;
      last_grant_reg <= 1'b1;
      addr_reg       <= '0;
      wdata_reg      <= '0;
      op_write_reg   <= 1'b0;
    end else begin
      state_reg      <= state_next;
      last_grant_reg <= last_grant_next;
      addr_reg       <= addr_next;
      wdata_reg      <= wdata_next;
      op_write_reg   <= op_write_next;
    end
  end

  // Next-state logic: grant in IDLE and capture the winner; release on L2 response
  always_comb begin
    state_next      = state_reg;
    last_grant_next = last_grant_reg;
    addr_next       = addr_reg;
    wdata_next      = wdata_reg;
    op_write_next   = op_write_reg;
    case (state_reg)
      IDLE: begin
        if (grant_i) begin
          state_next    = SERVE_I;
          addr_next     = i_pmem_address;
          wdata_next    = '0;
          op_write_next = 1'b0;
        end else if (grant_d) begin
          state_next    = SERVE_D;
          addr_next     = d_pmem_address;
          wdata_next    = d_pmem_wdata;
          // a write wins if the D-cache illegally raises both read and write
          op_write_next = d_pmem_write;
        end
      end
      SERVE_I: begin
        if (l2_mem_resp) begin
          state_next      = IDLE;
          last_grant_next = 1'b0;
        end
      end
      SERVE_D: begin
        if (l2_mem_resp) begin
          state_next      = IDLE;
          last_grant_next = 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Output steering: the L2 sees only latched values; only the owner sees resp/rdata
  always_comb begin
    l2_mem_read    = 1'b0;
    l2_mem_write   = 1'b0;
    l2_mem_address = '0;
    l2_mem_wdata   = '0;
    i_pmem_resp    = 1'b0;
    i_pmem_rdata   = '0;
    d_pmem_resp    = 1'b0;
    d_pmem_rdata   = '0;
    case (state_reg)
      SERVE_I: begin
        l2_mem_read    = 1'b1;
        l2_mem_address = addr_reg;
        i_pmem_resp    = l2_mem_resp;
        i_pmem_rdata   = l2_mem_rdata;
      end
      SERVE_D: begin
        l2_mem_read    = ~op_write_reg;
        l2_mem_write   = op_write_reg;
        l2_mem_address = addr_reg;
        l2_mem_wdata   = wdata_reg;
        d_pmem_resp    = l2_mem_resp;
        d_pmem_rdata   = l2_mem_rdata;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_l2_arbiter.sv
// tb_l2_arbiter: directed scenarios followed by a randomized phase, all
// checked every cycle against a transaction-level reference model.
module tb_l2_arbiter;

  localparam int ADDR_W = 16;
  localparam int LINE_W = 128;

  logic              clk = 1'b0;
  logic              reset;
  logic              i_pmem_read;
  logic [ADDR_W-1:0] i_pmem_address;
  logic [LINE_W-1:0] i_pmem_rdata;
  logic              i_pmem_resp;
  logic              d_pmem_read;
  logic              d_pmem_write;
  logic [ADDR_W-1:0] d_pmem_address;
  logic [LINE_W-1:0] d_pmem_wdata;
  logic [LINE_W-1:0] d_pmem_rdata;
  logic              d_pmem_resp;
  logic              l2_mem_read;
  logic              l2_mem_write;
  logic [ADDR_W-1:0] l2_mem_address;
  logic [LINE_W-1:0] l2_mem_wdata;
  logic [LINE_W-1:0] l2_mem_rdata;
  logic              l2_mem_resp;

  int checks   = 0;
  int failures = 0;

  // Reference model: who owns the L2 port (0 none, 1 I-cache, 2 D-cache)
  int                m_owner;
  logic              m_last;     // 1 when the D-cache was served last
  logic              m_new;      // owner was granted at the latest edge
  logic [ADDR_W-1:0] m_addr;
  logic [LINE_W-1:0] m_wdata;
  logic              m_wr;
  logic              ev_i_done;
  logic              ev_d_done;

  always #5 clk = ~clk;

  l2_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (
    .clk            (clk),
    .reset          (reset),
    .i_pmem_read    (i_pmem_read),
    .i_pmem_address (i_pmem_address),
    .i_pmem_rdata   (i_pmem_rdata),
    .i_pmem_resp    (i_pmem_resp),
    .d_pmem_read    (d_pmem_read),
    .d_pmem_write   (d_pmem_write),
    .d_pmem_address (d_pmem_address),
    .d_pmem_wdata   (d_pmem_wdata),
    .d_pmem_rdata   (d_pmem_rdata),
    .d_pmem_resp    (d_pmem_resp),
    .l2_mem_read    (l2_mem_read),
    .l2_mem_write   (l2_mem_write),
    .l2_mem_address (l2_mem_address),
    .l2_mem_wdata   (l2_mem_wdata),
    .l2_mem_rdata   (l2_mem_rdata),
    .l2_mem_resp    (l2_mem_resp)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: compare outputs to the model at the falling edge, then advance
  // the model and return 1 time unit after the rising edge.
  task automatic cycle();
    int                nxt;
    logic              nlast;
    logic              ir;
    logic              dr;
    logic [ADDR_W-1:0] naddr;
    logic [LINE_W-1:0] nwd;
    logic              nwr;
    @(negedge clk);
    chk("l2_mem_read",    l2_mem_read,    (m_owner == 1) || (m_owner == 2 && !m_wr));
    chk("l2_mem_write",   l2_mem_write,   (m_owner == 2) && m_wr);
    chk("l2_mem_address", l2_mem_address, (m_owner != 0) ? m_addr : 16'h0);
    chk("l2_mem_wdata",   l2_mem_wdata,   (m_owner == 2) ? m_wdata : 128'h0);
    chk("i_pmem_resp",    i_pmem_resp,    (m_owner == 1) && l2_mem_resp);
    chk("i_pmem_rdata",   i_pmem_rdata,   (m_owner == 1) ? l2_mem_rdata : 128'h0);
    chk("d_pmem_resp",    d_pmem_resp,    (m_owner == 2) && l2_mem_resp);
    chk("d_pmem_rdata",   d_pmem_rdata,   (m_owner == 2) ? d_pmem_rdata_exp() : 128'h0);
    ev_i_done = (m_owner == 1) && l2_mem_resp;
    ev_d_done = (m_owner == 2) && l2_mem_resp;
    nxt   = m_owner;
    nlast = m_last;
    naddr = m_addr;
    nwd   = m_wdata;
    nwr   = m_wr;
    if (reset) begin
      nxt   = 0;
      nlast = 1'b1;
    end else if (m_owner == 0) begin
      ir = i_pmem_read;
      dr = d_pmem_read | d_pmem_write;
      if (ir && dr) nxt = m_last ? 1 : 2;
      else if (ir)  nxt = 1;
      else if (dr)  nxt = 2;
      if (nxt == 1) begin
        naddr = i_pmem_address;
        nwd   = '0;
        nwr   = 1'b0;
      end else if (nxt == 2) begin
        naddr = d_pmem_address;
        nwd   = d_pmem_wdata;
        nwr   = d_pmem_write;
      end
    end else if (l2_mem_resp) begin
      nxt   = 0;
      nlast = (m_owner == 2);
    end
    @(posedge clk);
    #1;
    m_new   = (m_owner == 0) && (nxt != 0);
    m_owner = nxt;
    m_last  = nlast;
    m_addr  = naddr;
    m_wdata = nwd;
    m_wr    = nwr;
  endtask

  // The L2 read data is a bench-driven input, so it is the expected pass-through value
  function automatic logic [127:0] d_pmem_rdata_exp();
    return l2_mem_rdata;
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
  endtask

  logic [127:0] rdv;
  logic [127:0] wdv;
  logic         i_pend;
  logic         d_pend;
  int           lat;
  int           opsel;

  initial begin
    reset = 1'b1;
    i_pmem_read = 1'b0; i_pmem_address = '0;
    d_pmem_read = 1'b0; d_pmem_write = 1'b0; d_pmem_address = '0; d_pmem_wdata = '0;
    l2_mem_rdata = '0; l2_mem_resp = 1'b0;
    m_owner = 0; m_last = 1'b1; m_new = 1'b0;
    m_addr = '0; m_wdata = '0; m_wr = 1'b0;
    @(posedge clk);
    #1;
    // Reset state
    cycle();
    cycle();
    reset = 1'b0;

    // 1: lone I read, hit response forwarded in the same cycle
    i_pmem_read = 1'b1; i_pmem_address = 16'h1230;
    cycle();
    chk("t1_l2_read", l2_mem_read, 1'b1);
    chk("t1_l2_addr", l2_mem_address, 16'h1230);
    rdv = 128'hdeadbeef_01234567_89abcdef_cafef00d;
    l2_mem_resp = 1'b1; l2_mem_rdata = rdv;
    #1;
    chk("t1_i_resp", i_pmem_resp, 1'b1);
    chk("t1_i_rdata", i_pmem_rdata, rdv);
    chk("t1_d_resp", d_pmem_resp, 1'b0);
    cycle();
    i_pmem_read = 1'b0; l2_mem_resp = 1'b0;
    chk("t1_idle_read", l2_mem_read, 1'b0);

    // 2: simultaneous I read and D write after reset -> I first, gap, D write
    do_reset();
    wdv = 128'h11112222_33334444_55556666_77778888;
    i_pmem_read = 1'b1; i_pmem_address = 16'h0040;
    d_pmem_write = 1'b1; d_pmem_address = 16'h0080; d_pmem_wdata = wdv;
    cycle();
    chk("t2_first_addr", l2_mem_address, 16'h0040);
    chk("t2_first_read", l2_mem_read, 1'b1);
    l2_mem_resp = 1'b1;
    cycle();
    i_pmem_read = 1'b0; l2_mem_resp = 1'b0;
    chk("t2_gap_read", l2_mem_read, 1'b0);
    chk("t2_gap_write", l2_mem_write, 1'b0);
    cycle();
    chk("t2_d_write", l2_mem_write, 1'b1);
    chk("t2_d_addr", l2_mem_address, 16'h0080);
    chk("t2_d_wdata", l2_mem_wdata, wdv);
    l2_mem_resp = 1'b1;
    cycle();
    d_pmem_write = 1'b0; l2_mem_resp = 1'b0;
    cycle();

    // 3: continuous contention -> grants alternate I,D,I,D,I,D
    do_reset();
    i_pmem_read = 1'b1; i_pmem_address = 16'h0100;
    d_pmem_read = 1'b1; d_pmem_address = 16'h0200;
    for (int t = 0; t < 6; t++) begin
      cycle();
      chk("t3_grant_is_d", l2_mem_address == 16'h0200, (t % 2) == 1);
      l2_mem_resp = 1'b1;
      #1;
      chk("t3_d_resp", d_pmem_resp, (t % 2) == 1);
      chk("t3_i_resp", i_pmem_resp, (t % 2) == 0);
      cycle();
      l2_mem_resp = 1'b0;
    end
    i_pmem_read = 1'b0; d_pmem_read = 1'b0;
    cycle();

    // 4: D read 0x2000 with an 8-cycle miss; requester address moves mid-miss
    d_pmem_read = 1'b1; d_pmem_address = 16'h2000;
    cycle();
    d_pmem_address = 16'h3000;
    for (int k = 0; k < 7; k++) begin
      chk("t4_addr_held", l2_mem_address, 16'h2000);
      cycle();
    end
    chk("t4_addr_held", l2_mem_address, 16'h2000);
    rdv = 128'h0f0f0f0f_a5a5a5a5_5a5a5a5a_f0f0f0f0;
    l2_mem_resp = 1'b1; l2_mem_rdata = rdv;
    #1;
    chk("t4_d_resp", d_pmem_resp, 1'b1);
    chk("t4_d_rdata", d_pmem_rdata, rdv);
    cycle();
    d_pmem_read = 1'b0; l2_mem_resp = 1'b0;

    // 5: reset three cycles into a miss
    i_pmem_read = 1'b1; i_pmem_address = 16'h0500;
    cycle();
    cycle();
    cycle();
    cycle();
    reset = 1'b1;
    cycle();
    chk("t5_read", l2_mem_read, 1'b0);
    chk("t5_write", l2_mem_write, 1'b0);
    chk("t5_addr", l2_mem_address, 16'h0);
    chk("t5_wdata", l2_mem_wdata, 128'h0);
    reset = 1'b0; i_pmem_read = 1'b0;
    l2_mem_resp = 1'b1;
    #1;
    chk("t5_i_resp", i_pmem_resp, 1'b0);
    cycle();
    l2_mem_resp = 1'b0;

    // 6: illegal read+write -> write; then a stray L2 response in IDLE
    wdv = 128'h99990000_aaaabbbb_ccccdddd_eeeeffff;
    d_pmem_read = 1'b1; d_pmem_write = 1'b1;
    d_pmem_address = 16'h0abc; d_pmem_wdata = wdv;
    cycle();
    chk("t6_write", l2_mem_write, 1'b1);
    chk("t6_read", l2_mem_read, 1'b0);
    l2_mem_resp = 1'b1;
    cycle();
    d_pmem_read = 1'b0; d_pmem_write = 1'b0; l2_mem_resp = 1'b0;
    cycle();
    l2_mem_resp = 1'b1;
    #1;
    chk("t6_stray_i_resp", i_pmem_resp, 1'b0);
    chk("t6_stray_d_resp", d_pmem_resp, 1'b0);
    cycle();
    l2_mem_resp = 1'b0;

    // Randomized traffic against the model
    i_pend = 1'b0; d_pend = 1'b0; lat = 0;
    for (int n = 0; n < 3000; n++) begin
      cycle();
      if (reset) begin
        reset = 1'b0;
        i_pmem_read = 1'b0; d_pmem_read = 1'b0; d_pmem_write = 1'b0;
        i_pend = 1'b0; d_pend = 1'b0;
      end else begin
        if (ev_i_done) begin
          i_pmem_read = 1'b0; i_pend = 1'b0;
        end else if (!i_pend && $urandom_range(0, 2) == 0) begin
          i_pmem_read = 1'b1; i_pend = 1'b1;
          i_pmem_address = 16'($urandom);
        end else if (i_pend && $urandom_range(0, 3) == 0) begin
          i_pmem_address = 16'($urandom);
        end
        if (ev_d_done) begin
          d_pmem_read = 1'b0; d_pmem_write = 1'b0; d_pend = 1'b0;
        end else if (!d_pend && $urandom_range(0, 2) == 0) begin
          opsel = $urandom_range(0, 7);
          d_pmem_read  = (opsel == 0) || (opsel > 3);
          d_pmem_write = (opsel <= 3);
          d_pend = 1'b1;
          d_pmem_address = 16'($urandom);
          d_pmem_wdata = {$urandom, $urandom, $urandom, $urandom};
        end else if (d_pend && $urandom_range(0, 3) == 0) begin
          d_pmem_address = 16'($urandom);
          d_pmem_wdata = {$urandom, $urandom, $urandom, $urandom};
        end
        if ($urandom_range(0, 299) == 0) reset = 1'b1;
      end
      if (m_owner != 0) begin
        if (m_new) lat = $urandom_range(0, 4);
        l2_mem_resp = (lat == 0);
        if (lat > 0) lat--;
      end else begin
        l2_mem_resp = ($urandom_range(0, 5) == 0);
      end
      l2_mem_rdata = {$urandom, $urandom, $urandom, $urandom};
    end
    reset = 1'b0;
    i_pmem_read = 1'b0; d_pmem_read = 1'b0; d_pmem_write = 1'b0; l2_mem_resp = 1'b0;
    cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
